// File: rtl/address_register_unit.sv
// Address register unit: program counter and memory address register.
// Assembles 16-bit operand addresses from two consecutive data-bus bytes
// (low byte first) into MAR or PC. Also performs PC increment, signed relative
// branch, MAR copy-from-PC and MAR increment under control-unit strobes.
//
// Handshake: data_in is consumed on a rising edge where data_valid=1 and
// the unit is busy (WAIT_LO/WAIT_HI) and abort=0. There is no ready signal;
// the control unit must only present operand bytes while busy is high.
module address_register_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] MAR_RESET    = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        addr_start,
  input  logic        addr_target,
  input  logic        abort,
  input  logic        pc_inc,
  input  logic        pc_rel,
  input  logic        mar_from_pc,
  input  logic        mar_inc,
  output logic [15:0] pc_value,
  output logic [15:0] mar_value,
  output logic        busy,
  output logic        addr_ready,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WAIT_HI = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  lo_byte;
  logic        target_pc;

  logic        in_assembly;
  logic        byte_accept;
  logic        asm_write;
  logic [15:0] asm_addr;
  logic [15:0] rel_offset;

  // Decode the current cycle's assembly events; abort beats data_valid.
  always_comb begin
    in_assembly = (state == WAIT_LO) || (state == WAIT_HI);
    byte_accept = in_assembly && data_valid && !abort;
    asm_write   = (state == WAIT_HI) && data_valid && !abort;
    asm_addr    = {data_in, lo_byte};
    rel_offset  = {{8{data_in[7]}}, data_in};
  end

  assign busy      = in_assembly;
  assign state_dbg = state;

  // Assembly FSM: tracks start, low byte, high byte, and the done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lo_byte    <= 8'h00;
      target_pc  <= 1'b0;
      addr_ready <= 1'b0;
    end else begin
      addr_ready <= asm_write;
      case (state)
        IDLE: begin
          if (addr_start) begin
            state     <= WAIT_LO;
            target_pc <= addr_target;
          end
        end
        WAIT_LO: begin
          if (abort) begin
            state <= IDLE;
          end else if (data_valid) begin
            lo_byte <= data_in;
            state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (abort) begin
            state <= IDLE;
          end else if (data_valid) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Program counter: jump write, then relative branch, then +1 step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_value <= RESET_VECTOR;
    end else if (asm_write && target_pc) begin
      pc_value <= asm_addr;
    end else if (pc_rel) begin
      pc_value <= pc_value + rel_offset;
    end else if (pc_inc || byte_accept) begin
      pc_value <= pc_value + 16'd1;
    end
  end

  // Memory address register: operand write, then copy of pre-edge PC, then +1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mar_value <= MAR_RESET;
    end else if (asm_write && !target_pc) begin
      mar_value <= asm_addr;
    end else if (mar_from_pc) begin
      mar_value <= pc_value;
    end else if (mar_inc) begin
      mar_value <= mar_value + 16'd1;
    end
  end

endmodule

// File: tb/tb_address_register_unit.sv
// Testbench for address_register_unit with a transaction-level reference model.
module tb_address_register_unit;

  localparam logic [15:0] RV   = 16'h0100;
  localparam logic [15:0] MRST = 16'h0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        addr_start = 1'b0;
  logic        addr_target = 1'b0;
  logic        abort = 1'b0;
  logic        pc_inc = 1'b0;
  logic        pc_rel = 1'b0;
  logic        mar_from_pc = 1'b0;
  logic        mar_inc = 1'b0;
  logic [15:0] pc_value;
  logic [15:0] mar_value;
  logic        busy;
  logic        addr_ready;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_mar;
  int          m_phase;   // 0 idle, 1 need low byte, 2 need high byte, 3 done
  logic        m_tgt;
  logic [7:0]  byte_q[$];
  logic [16:0] exp_q[$];  // {target, address} of completed assemblies

  address_register_unit #(.RESET_VECTOR(RV), .MAR_RESET(MRST)) dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .addr_start(addr_start), .addr_target(addr_target), .abort(abort),
    .pc_inc(pc_inc), .pc_rel(pc_rel), .mar_from_pc(mar_from_pc), .mar_inc(mar_inc),
    .pc_value(pc_value), .mar_value(mar_value), .busy(busy),
    .addr_ready(addr_ready), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_pc = RV;
    m_mar = MRST;
    m_phase = 0;
    m_tgt = 1'b0;
    byte_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_tick();
    bit consume;
    bit done;
    logic [15:0] addr;
    logic [15:0] old_pc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    old_pc = m_pc;
    consume = (m_phase == 1 || m_phase == 2) && data_valid && !abort;
    done = 0;
    addr = 16'h0000;
    if (consume) begin
      byte_q.push_back(data_in);
      if (byte_q.size() == 2) begin
        done = 1;
        addr = 16'(int'(byte_q[1]) * 256 + int'(byte_q[0]));
      end
    end
    // PC
    if (done && m_tgt) m_pc = addr;
    else if (pc_rel) m_pc = 16'(int'(m_pc) + int'($signed(data_in)));
    else if (pc_inc || consume) m_pc = 16'(int'(m_pc) + 1);
    // MAR
    if (done && !m_tgt) m_mar = addr;
    else if (mar_from_pc) m_mar = old_pc;
    else if (mar_inc) m_mar = 16'(int'(m_mar) + 1);
    if (done) exp_q.push_back({m_tgt, addr});
    // phase
    if (m_phase == 0) begin
      if (addr_start) begin
        m_phase = 1;
        m_tgt = addr_target;
        byte_q.delete();
      end
    end else if (m_phase == 3) begin
      m_phase = 0;
    end else if (abort) begin
      m_phase = 0;
      byte_q.delete();
    end else if (done) begin
      m_phase = 3;
      byte_q.delete();
    end else if (consume) begin
      m_phase = 2;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_in();
    data_in = 8'h00; data_valid = 0; addr_start = 0; addr_target = 0; abort = 0;
    pc_inc = 0; pc_rel = 0; mar_from_pc = 0; mar_inc = 0;
  endtask

  // One cycle: model sees pre-edge inputs, DUT samples on edge, outputs read 1ns later.
  task automatic tick();
    model_tick();
    @(posedge clock);
    #1;
    clear_in();
  endtask

  // Drive a full PC jump sequence (checked elsewhere).
  task automatic load_pc(input logic [15:0] a);
    addr_start = 1; addr_target = 1; tick();
    data_valid = 1; data_in = a[7:0]; tick();
    data_valid = 1; data_in = a[15:8]; tick();
    tick();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0;
    clear_in();
    model_reset();
    @(posedge clock); @(posedge clock); #1;
    checks++; if (pc_value !== RV) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_value, RV); end
    checks++; if (mar_value !== MRST) begin errors++; $display("FAIL reset_mar: got %h expected %h", mar_value, MRST); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", addr_ready); end
    reset_n = 1;
    pc_inc = 1; tick();
    pc_inc = 1; tick();
    checks++; if (pc_value !== 16'h0102) begin errors++; $display("FAIL reset_pc_inc2: got %h expected 0102", pc_value); end
  endtask

  task automatic test_mar_assembly();
    logic [15:0] pc0;
    pc0 = m_pc;
    addr_start = 1; addr_target = 0; tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mar_busy_lo: got %b expected 1", busy); end
    data_valid = 1; data_in = 8'h34; tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mar_busy_hi: got %b expected 1", busy); end
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL mar_early_ready: got %b expected 0", addr_ready); end
    data_valid = 1; data_in = 8'h12; tick();
    checks++; if (mar_value !== 16'h1234) begin errors++; $display("FAIL mar_value: got %h expected 1234", mar_value); end
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL mar_ready: got %b expected 1", addr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mar_busy_done: got %b expected 0", busy); end
    checks++; if (pc_value !== pc0 + 16'd2) begin errors++; $display("FAIL mar_pc_step: got %h expected %h", pc_value, pc0 + 16'd2); end
    addr_start = 1; addr_target = 1; tick();   // addr_start in DONE is ignored
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL mar_ready_pulse: got %b expected 0", addr_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: got %b expected 0", busy); end
    exp_q.delete();
  endtask

  task automatic test_pc_jump();
    logic [15:0] mar0;
    load_pc(16'h0010);
    checks++; if (pc_value !== 16'h0010) begin errors++; $display("FAIL jump_setup: got %h expected 0010", pc_value); end
    mar0 = mar_value;
    addr_start = 1; addr_target = 1; tick();
    data_valid = 1; data_in = 8'hCD; tick();
    checks++; if (pc_value !== 16'h0011) begin errors++; $display("FAIL jump_lo_step: got %h expected 0011", pc_value); end
    data_valid = 1; data_in = 8'hAB; tick();
    checks++; if (pc_value !== 16'hABCD) begin errors++; $display("FAIL jump_pc: got %h expected abcd", pc_value); end
    checks++; if (mar_value !== mar0) begin errors++; $display("FAIL jump_mar_hold: got %h expected %h", mar_value, mar0); end
    checks++; if (addr_ready !== 1'b1) begin errors++; $display("FAIL jump_ready: got %b expected 1", addr_ready); end
    tick();
    exp_q.delete();
  endtask

  task automatic test_wrap();
    load_pc(16'h0002);
    pc_rel = 1; data_in = 8'hFC; tick();
    checks++; if (pc_value !== 16'hFFFE) begin errors++; $display("FAIL rel_neg_wrap: got %h expected fffe", pc_value); end
    load_pc(16'hFFFF);
    pc_inc = 1; tick();
    checks++; if (pc_value !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h expected 0000", pc_value); end
    load_pc(16'h7FF0);
    pc_rel = 1; data_in = 8'h20; tick();
    checks++; if (pc_value !== 16'h8010) begin errors++; $display("FAIL rel_pos: got %h expected 8010", pc_value); end
    pc_rel = 1; pc_inc = 1; data_in = 8'h80; tick();   // rel beats inc
    checks++; if (pc_value !== 16'h7F90) begin errors++; $display("FAIL rel_over_inc: got %h expected 7f90", pc_value); end
  endtask

  task automatic test_abort();
    logic [15:0] mar0;
    mar0 = mar_value;
    addr_start = 1; addr_target = 0; tick();
    data_valid = 1; data_in = 8'h55; tick();
    abort = 1; data_valid = 1; data_in = 8'h99; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", addr_ready); end
    checks++; if (mar_value !== mar0) begin errors++; $display("FAIL abort_mar: got %h expected %h", mar_value, mar0); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", state_dbg); end
    tick();
    checks++; if (addr_ready !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: got %b expected 0", addr_ready); end
    addr_start = 1; addr_target = 0; tick();
    data_valid = 1; data_in = 8'h78; tick();
    data_valid = 1; data_in = 8'h56; tick();
    checks++; if (mar_value !== 16'h5678) begin errors++; $display("FAIL abort_reassemble: got %h expected 5678", mar_value); end
    tick();
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic [15:0] pc0;
    addr_start = 1; addr_target = 0; tick();
    data_valid = 1; data_in = 8'h11; tick();     // now WAIT_HI
    #2 reset_n = 0;
    #1;
    checks++; if (pc_value !== RV) begin errors++; $display("FAIL async_pc: got %h expected %h", pc_value, RV); end
    checks++; if (mar_value !== MRST) begin errors++; $display("FAIL async_mar: got %h expected %h", mar_value, MRST); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    data_valid = 1; data_in = 8'h22;
    tick();                                       // held in reset across an edge
    reset_n = 1;
    tick();
    checks++; if (mar_value !== MRST) begin errors++; $display("FAIL async_no_write: got %h expected %h", mar_value, MRST); end
    // addr_start while busy is ignored (target stays MAR)
    addr_start = 1; addr_target = 0; tick();
    addr_start = 1; addr_target = 1; tick();
    pc0 = pc_value;
    data_valid = 1; data_in = 8'hEF; tick();
    data_valid = 1; data_in = 8'hBE; tick();
    checks++; if (mar_value !== 16'hBEEF) begin errors++; $display("FAIL busy_start_mar: got %h expected beef", mar_value); end
    checks++; if (pc_value !== pc0 + 16'd2) begin errors++; $display("FAIL busy_start_pc: got %h expected %h", pc_value, pc0 + 16'd2); end
    tick();
    pc0 = pc_value;
    mar_from_pc = 1; mar_inc = 1; pc_inc = 1; tick();
    checks++; if (mar_value !== pc0) begin errors++; $display("FAIL mar_from_pc_prio: got %h expected %h", mar_value, pc0); end
    checks++; if (pc_value !== pc0 + 16'd1) begin errors++; $display("FAIL pc_parallel_inc: got %h expected %h", pc_value, pc0 + 16'd1); end
    mar_inc = 1; tick();
    checks++; if (mar_value !== pc0 + 16'd1) begin errors++; $display("FAIL mar_inc: got %h expected %h", mar_value, pc0 + 16'd1); end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [16:0] e;
    logic [15:0] act;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      addr_start  = ($urandom_range(0, 3) == 0);
      addr_target = $urandom_range(0, 1);
      data_valid  = ($urandom_range(0, 2) != 0);
      data_in     = 8'($urandom_range(0, 255));
      abort       = ($urandom_range(0, 15) == 0);
      pc_inc      = ($urandom_range(0, 3) == 0);
      pc_rel      = ($urandom_range(0, 5) == 0);
      mar_from_pc = ($urandom_range(0, 5) == 0);
      mar_inc     = ($urandom_range(0, 3) == 0);
      tick();
      checks++; if (pc_value !== m_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, pc_value, m_pc); end
      checks++; if (mar_value !== m_mar) begin errors++; $display("FAIL rand_mar[%0d]: got %h expected %h", i, mar_value, m_mar); end
      checks++; if (busy !== (m_phase == 1 || m_phase == 2)) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, busy, (m_phase == 1 || m_phase == 2)); end
      checks++; if (addr_ready !== (m_phase == 3)) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, addr_ready, (m_phase == 3)); end
      if (addr_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_sb_empty[%0d]: got addr_ready=1 expected no completion", i);
        end else begin
          e = exp_q.pop_front();
          act = e[16] ? pc_value : mar_value;
          if (act !== e[15:0]) begin errors++; $display("FAIL rand_sb_addr[%0d]: got %h expected %h", i, act, e[15:0]); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_sb_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_mar_assembly();
    test_pc_jump();
    test_wrap();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/address_register_unit.md
Name: address_register_unit

Overview:
- Holds the program counter and memory address register and drives pc_value / mar_value into the address multiplexer directly downstream.
- Assembles 16-bit operand addresses from two consecutive 8-bit data-bus bytes, low byte first, into either MAR (memory operand) or PC (absolute jump).
- Also supports PC increment, signed relative branch, and MAR copy-from-PC and increment.
- Driven by strobes from the control unit; no knowledge of state encodings.

Parameters:
RESET_VECTOR, 16'h0000, PC value after reset
MAR_RESET, 16'h0000, MAR value after reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
data_in  input  8  data bus byte (operand byte or relative offset)
data_valid  input  1  data_in holds a valid operand byte this cycle
addr_start  input  1  begin two-byte address assembly
addr_target  input  1  destination of assembled address: 0 = MAR, 1 = PC; sampled with addr_start
abort  input  1  cancel assembly in progress
pc_inc  input  1  PC <= PC + 1
pc_rel  input  1  PC <= PC + sign-extended data_in
mar_from_pc  input  1  MAR <= PC
mar_inc  input  1  MAR <= MAR + 1
pc_value  output  16  current PC
mar_value  output  16  current MAR
busy  output  1  assembly in progress (state WAIT_LO or WAIT_HI)
addr_ready  output  1  one-cycle pulse: assembled address written last edge

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous):
  - pc_value = RESET_VECTOR, mar_value = MAR_RESET.
  - low-byte holding register = 8'h00, target flag = 0.
  - FSM = IDLE, busy = 0, addr_ready = 0.
  - Reset mid-assembly discards the partial byte; no register write.
- FSM states: IDLE, WAIT_LO, WAIT_HI, DONE.
  - IDLE: addr_start=1 -> WAIT_LO, latch addr_target. Otherwise stay.
  - WAIT_LO: data_valid=1 -> capture data_in into low-byte register, go to WAIT_HI.
  - WAIT_HI: data_valid=1 -> write {data_in, low byte} to the target register, go to DONE.
  - DONE: addr_ready=1 for exactly this cycle, then IDLE unconditionally. addr_start in DONE is ignored.
  - abort=1 in WAIT_LO or WAIT_HI -> IDLE next edge, no write, no addr_ready. abort has priority over data_valid. abort in IDLE or DONE has no effect.
  - addr_start while busy is ignored.
- Outputs and latency:
  - busy is combinational from state (WAIT_LO | WAIT_HI).
  - addr_ready is registered (state == DONE).
  - Latency: addr_start at edge N; bytes on the next two data_valid cycles; target updated on the edge sampling the high byte; addr_ready high the following cycle.
- Operand consumption: each accepted data_valid in WAIT_LO or WAIT_HI also increments PC by 1 (PC steps past operand bytes).
- PC update priority, highest first:
  1. assembly write with target = PC
  2. pc_rel: PC + {{8{data_in[7]}}, data_in}
  3. pc_inc or operand-byte consumption (+1 only, never +2)
  4. hold
- MAR update priority, highest first:
  1. assembly write with target = MAR
  2. mar_from_pc (uses pre-edge PC)
  3. mar_inc
  4. hold
- Arithmetic: all arithmetic is modulo 2^16. Wrap-around is silent: 16'hFFFF+1 = 16'h0000; 16'h0002 + 8'hFC = 16'hFFFE.
- Simultaneous PC and MAR events are independent and both take effect.
- pc_value and mar_value are direct register outputs, stable between rising edges.

Test Plan:
- Reset with RESET_VECTOR = 16'h0100 -> pc_value=16'h0100, mar_value=16'h0000, busy=0, addr_ready=0; deassert and pulse pc_inc twice -> pc_value=16'h0102.
- addr_start with target=0, then data 8'h34, 8'h12 with data_valid -> mar_value=16'h1234 after the second byte, addr_ready pulses one cycle, pc_value advanced by 2, busy high only during WAIT_LO and WAIT_HI.
- PC=16'h0010, addr_start with target=1, bytes 8'hCD, 8'hAB -> pc_value=16'hABCD (jump overrides operand increment), mar_value unchanged.
- PC=16'h0002, pc_rel with data_in=8'hFC -> 16'hFFFE. PC=16'hFFFF, pc_inc -> 16'h0000. PC=16'h7FF0, pc_rel with 8'h20 -> 16'h8010.
- Assembly aborted after low byte 8'h55 (abort and data_valid both high) -> MAR unchanged, no addr_ready, FSM in IDLE. New assembly with 8'h78, 8'h56 -> mar_value=16'h5678; low byte 8'h55 is not reused.
- reset_n pulsed low asynchronously between clock edges during WAIT_HI -> outputs return to reset values immediately; MAR unchanged from MAR_RESET; addr_start ignored while busy; mar_from_pc and mar_inc in the same cycle -> MAR = old PC.
